// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: program counter, writable instruction memory and the
// IDLE/RUN/HALT control that feeds one instruction per cycle to decode.
module instruction_fetch_stage #(
  parameter int          PC_WIDTH   = 8,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [5:0]  HALT_OP    = 6'b111111
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                prog_we,
  input  logic [PC_WIDTH-1:0] prog_addr,
  input  logic [31:0]         prog_data,
  output logic [31:0]         ins,
  output logic                ins_valid,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                halted
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         imem [IMEM_DEPTH];
  logic [31:0]         fetch_word;
  logic                fetch_is_halt;

  // Asynchronous read: the word at pc is available within the current cycle,
  // giving the one-cycle fetch latency.
  assign fetch_word    = imem[pc];
  assign fetch_is_halt = (fetch_word[31:26] == HALT_OP);

  // NOTE: the memory array has no reset; it keeps its program across reset and
  // maps onto plain RAM. A write during reset is suppressed so reset leaves it
  // untouched.
  always_ff @(posedge clk) begin
    if (reset && prog_we && (state == ST_IDLE)) begin
      imem[prog_addr] <= prog_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pc        <= '0;
      ins       <= '0;
      ins_valid <= 1'b0;
      pc_out    <= '0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          ins       <= '0;
          ins_valid <= 1'b0;
          pc        <= '0;
          if (start) begin
            state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (branch_taken) begin
            // Redirect and flush the slot; pc_out keeps the last real address.
            pc        <= branch_target;
            ins       <= '0;
            ins_valid <= 1'b0;
          end else if (!stall) begin
            if (fetch_is_halt) begin
              // The halt word is swallowed and pc parks on its address.
              ins       <= '0;
              ins_valid <= 1'b0;
              halted    <= 1'b1;
              state     <= ST_HALT;
            end else begin
              ins       <= fetch_word;
              pc_out    <= pc;
              ins_valid <= 1'b1;
              pc        <= pc + PC_ONE;
            end
          end
        end

        ST_HALT: begin
          ins       <= '0;
          ins_valid <= 1'b0;
          if (start) begin
            state  <= ST_RUN;
            pc     <= '0;
            halted <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction fetch stage of the 5-stage MIPS pipeline, directly upstream of the dependency check / decode block. Holds the program counter and a writable instruction memory, and presents one 32-bit instruction per cycle on `ins`. Supports decode-stage stalls, branch redirection with a one-slot flush, and a halt opcode that freezes fetch. Instruction memory is loaded through a program port while the stage is idle.

## Interface
Parameters:
- `PC_WIDTH`, 8: word-address width of PC and instruction memory.
- `IMEM_DEPTH`, 256: instruction words; must equal 2^PC_WIDTH.
- `HALT_OP`, 6'b111111: opcode (`ins[31:26]`) that halts fetch.

Ports:
- `clk` input, 1: single clock; all state updates on the rising edge.
- `reset` input, 1: asynchronous, active-low; clears all state when low.
- `start` input, 1: pulse; from IDLE or HALT, begins fetching at word 0.
- `stall` input, 1: decode is not accepting; hold `ins`, `pc_out`, `ins_valid` and PC.
- `branch_taken` input, 1: redirect fetch to `branch_target` and flush the current slot.
- `branch_target` input, PC_WIDTH: word address of the next instruction after a taken branch.
- `prog_we` input, 1: instruction memory write enable; honoured only in IDLE.
- `prog_addr` input, PC_WIDTH: write word address.
- `prog_data` input, 32: write data.
- `ins` output, 32: instruction to decode.
- `ins_valid` output, 1: `ins` is a real instruction, not a bubble.
- `pc_out` output, PC_WIDTH: word address `ins` was fetched from.
- `halted` output, 1: high in HALT.

## Operation
States:
- IDLE: entered on reset. Program writes are honoured. PC is held at 0.
- RUN: fetch active.
- HALT: fetch frozen.

Transitions:
- IDLE → RUN on `start`.
- RUN → HALT when the word fetched has opcode HALT_OP.
- HALT → RUN on `start`, with PC set to 0. Memory contents are kept.
- `start` in RUN is ignored.

Each RUN cycle, priority is reset > `branch_taken` > `stall` > normal:
- Normal: `ins` <= imem[pc], `pc_out` <= pc, `ins_valid` <= 1, pc <= pc+1. PC wraps from 2^PC_WIDTH-1 to 0 with no flag.
- Stall: all registers hold.
- Branch: pc <= `branch_target`, `ins` <= 0, `ins_valid` <= 0, `pc_out` holds. A branch overrides a simultaneous stall.
- Halt word fetched: it is not forwarded. `ins` <= 0, `ins_valid` <= 0, pc holds at the halt word's address, state → HALT. If `branch_taken` is asserted in the same cycle, the branch wins and no halt occurs.

Other rules:
- A bubble is always `ins` = 32'h0 with `ins_valid` = 0. Decode must qualify on `ins_valid`.
- In IDLE and HALT: `ins` = 0, `ins_valid` = 0; `stall` and `branch_taken` are ignored.
- `prog_we` outside IDLE is ignored; memory is unchanged.
- Memory contents are not cleared by reset.

## Timing
- Reset values (asynchronous, while `reset` is low): state IDLE, pc 0, `ins` 32'h0, `ins_valid` 0, `pc_out` 0, `halted` 0.
- Fetch latency: one cycle. `start` sampled at edge N gives imem[0] on `ins` after edge N+1, then one new word per edge.
- Branch: `branch_taken` sampled at edge N gives a bubble after N; imem[`branch_target`] appears after N+1.
- Stall: outputs are unchanged during every edge where `stall` is high. The next word appears on the first edge with `stall` low.
- `halted` rises on the same edge that enters HALT and falls on the edge that leaves it.
- Program write: takes effect at the edge where `prog_we` is sampled. The word is readable by fetch from the next cycle.
- Reset asserted mid-RUN: outputs go to their reset values immediately, without waiting for a clock edge.

## Test plan
- Load imem[0..3] = 0x00221800, 0x50810000, 0x10A12000, 0x34C10005, then pulse `start`: `ins` shows those four words on four consecutive edges, `pc_out` = 0,1,2,3, `ins_valid` = 1.
- During that run, hold `stall` high for 2 cycles while `ins` = 0x50810000: `ins` and `pc_out` = 1 are held; 0x10A12000 follows on the release edge.
- Assert `branch_taken` with `branch_target` = 8 while pc = 2 (imem[8] = 0xDEADBEEF): one bubble (`ins` = 0, `ins_valid` = 0), then `ins` = 0xDEADBEEF, `pc_out` = 8. Repeat with `stall` also high: the branch still wins.
- Put 0xFC000000 at word 4: after word 3, `ins_valid` = 0, `halted` = 1, pc holds at 4. A `prog_we` during HALT leaves memory unchanged; `start` refetches from word 0.
- Branch to 255 with imem[255] = 0x11111111: `pc_out` = 255, then `pc_out` = 0 and `ins` = imem[0] (wrap-around).
- Drop `reset` low between edges mid-RUN: `ins` = 0, `ins_valid` = 0, `pc_out` = 0 immediately. After release, state is IDLE and memory contents are intact.
